// File: rtl/branch_sequencer_pkg.sv
// Shared types for the branch sequencer: jump condition codes, flag register layout, FSM states.
package branch_sequencer_pkg;

    typedef enum logic [3:0] {
        COND_AL = 4'd0,
        COND_EQ = 4'd1,
        COND_NE = 4'd2,
        COND_CS = 4'd3,
        COND_CC = 4'd4,
        COND_MI = 4'd5,
        COND_PL = 4'd6,
        COND_VS = 4'd7,
        COND_VC = 4'd8,
        COND_HI = 4'd9,
        COND_LS = 4'd10,
        COND_GE = 4'd11,
        COND_LT = 4'd12,
        COND_GT = 4'd13,
        COND_LE = 4'd14,
        COND_NV = 4'd15
    } cond_e;

    // Bit order matches the {N,Z,C,V} ALU flag bus.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_HALT     = 2'd3
    } state_e;

endpackage

// File: rtl/branch_sequencer_cond_eval.sv
// cond_eval: purely combinational evaluation of a jump condition code against a flags value.
module branch_sequencer_cond_eval
    import branch_sequencer_pkg::*;
(
    input  flags_t flags,
    input  cond_e  cond,
    output logic   cond_true
);

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_AL: cond_true = 1'b1;
            COND_EQ: cond_true = flags.z;
            COND_NE: cond_true = !flags.z;
            COND_CS: cond_true = flags.c;
            COND_CC: cond_true = !flags.c;
            COND_MI: cond_true = flags.n;
            COND_PL: cond_true = !flags.n;
            COND_VS: cond_true = flags.v;
            COND_VC: cond_true = !flags.v;
            COND_HI: cond_true = flags.c && !flags.z;
            COND_LS: cond_true = !flags.c || flags.z;
            COND_GE: cond_true = (flags.n == flags.v);
            COND_LT: cond_true = (flags.n != flags.v);
            COND_GT: cond_true = !flags.z && (flags.n == flags.v);
            COND_LE: cond_true = flags.z || (flags.n != flags.v);
            COND_NV: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_sequencer.sv
// Fetch-PC sequencer: holds the N/Z/C/V flags, resolves jumps from execute and redirects/flushes fetch.
module branch_sequencer
    import branch_sequencer_pkg::*;
#(
    parameter int                   REG_WIDTH = 16,
    parameter logic [REG_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_valid,
    input  logic [REG_WIDTH-1:0] ex_pc,
    input  logic                 jmp,
    input  logic [3:0]           jmpcond,
    input  logic [REG_WIDTH-1:0] joffset,
    input  logic                 nzen,
    input  logic                 cven,
    input  logic [3:0]           alu_flags,
    input  logic                 halt_req,
    input  logic                 fetch_rdy,
    output logic [REG_WIDTH-1:0] pc,
    output logic                 pc_valid,
    output logic                 flush,
    output logic                 taken,
    output logic [3:0]           flags,
    output logic                 halted
);

    localparam logic [REG_WIDTH-1:0] PC_ONE = {{(REG_WIDTH-1){1'b0}}, 1'b1};

    state_e state, state_nxt;
    flags_t flags_q;
    logic   cond_true;
    logic   jump_eval;
    logic   jump_taken;
    logic   flag_wr;

    // Condition is judged on the held flags, so a same-cycle flag write cannot affect it.
    branch_sequencer_cond_eval u_cond_eval (
        .flags     (flags_q),
        .cond      (cond_e'(jmpcond)),
        .cond_true (cond_true)
    );

    assign flags = flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_BOOT;
            pc_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc_valid <= (state_nxt == ST_RUN);
            halted   <= (state_nxt == ST_HALT);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_BOOT:     state_nxt = ST_RUN;
            ST_RUN: begin
                if (jump_taken)    state_nxt = ST_REDIRECT;
                else if (halt_req) state_nxt = ST_HALT;
                else               state_nxt = ST_RUN;
            end
            ST_REDIRECT: state_nxt = ST_RUN;
            ST_HALT:     state_nxt = halt_req ? ST_HALT : ST_RUN;
            default:     state_nxt = ST_BOOT;
        endcase
    end

    // Execute is only listened to in RUN (jumps) and RUN/HALT (flag writes).
    always_comb begin
        flush      = (state == ST_REDIRECT);
        jump_eval  = (state == ST_RUN) && ex_valid && jmp;
        jump_taken = jump_eval && cond_true;
        flag_wr    = ex_valid && ((state == ST_RUN) || (state == ST_HALT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            taken   <= 1'b0;
            flags_q <= '0;
        end else begin
            if (jump_taken)
                pc <= ex_pc + joffset;
            else if ((state == ST_RUN) && fetch_rdy)
                pc <= pc + PC_ONE;

            if (jump_eval)
                taken <= cond_true;

            if (flag_wr && nzen) begin
                flags_q.n <= alu_flags[3];
                flags_q.z <= alu_flags[2];
            end
            if (flag_wr && cven) begin
                flags_q.c <= alu_flags[1];
                flags_q.v <= alu_flags[0];
            end
        end
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench for branch_sequencer: per-cycle expected outputs queued with stimulus, compared per scenario.
module tb_branch_sequencer;

    typedef struct packed {
        logic        pv;
        logic [15:0] pc;
        logic        fl;
        logic        tk;
        logic [3:0]  fg;
        logic        hl;
    } exp_t;

    typedef struct packed {
        logic        ev;
        logic [15:0] expc;
        logic        j;
        logic [3:0]  cond;
        logic [15:0] joff;
        logic        nz;
        logic        cv;
        logic [3:0]  af;
        logic        hr;
        logic        fr;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid, jmp, nzen, cven, halt_req, fetch_rdy;
    logic [15:0] ex_pc, joffset;
    logic [3:0]  jmpcond, alu_flags;
    logic [15:0] pc;
    logic        pc_valid, flush, taken, halted;
    logic [3:0]  flags;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t sb_exp[$];
    exp_t sb_obs[$];

    branch_sequencer #(.REG_WIDTH(16), .RESET_PC(16'h0100)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ex_valid  (ex_valid),
        .ex_pc     (ex_pc),
        .jmp       (jmp),
        .jmpcond   (jmpcond),
        .joffset   (joffset),
        .nzen      (nzen),
        .cven      (cven),
        .alu_flags (alu_flags),
        .halt_req  (halt_req),
        .fetch_rdy (fetch_rdy),
        .pc        (pc),
        .pc_valid  (pc_valid),
        .flush     (flush),
        .taken     (taken),
        .flags     (flags),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(logic pv, logic [15:0] p, logic fl, logic tk, logic [3:0] fg, logic hl);
        exp_t e;
        e.pv = pv; e.pc = p; e.fl = fl; e.tk = tk; e.fg = fg; e.hl = hl;
        return e;
    endfunction

    function automatic stim_t st(logic ev, logic [15:0] expc, logic j, logic [3:0] cond, logic [15:0] joff,
                                 logic nz, logic cv, logic [3:0] af, logic hr, logic fr);
        stim_t s;
        s.ev = ev; s.expc = expc; s.j = j; s.cond = cond; s.joff = joff;
        s.nz = nz; s.cv = cv; s.af = af; s.hr = hr; s.fr = fr;
        return s;
    endfunction

    function automatic stim_t idle(logic fr);
        return st(1'b0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b0, fr);
    endfunction

    function automatic exp_t obs();
        return exp_t'({pc_valid, pc, flush, taken, flags, halted});
    endfunction

    function automatic string fmt(exp_t e);
        return $sformatf("pv=%b pc=%h fl=%b tk=%b fg=%b hl=%b", e.pv, e.pc, e.fl, e.tk, e.fg, e.hl);
    endfunction

    task automatic apply(input stim_t s);
        ex_valid = s.ev; ex_pc = s.expc; jmp = s.j; jmpcond = s.cond; joffset = s.joff;
        nzen = s.nz; cven = s.cv; alu_flags = s.af; halt_req = s.hr; fetch_rdy = s.fr;
    endtask

    // Drive one cycle, queue what the outputs must be after the edge, capture what they are.
    task automatic cyc(input stim_t s, input exp_t e);
        apply(s);
        sb_exp.push_back(e);
        @(posedge clk);
        #1;
        sb_obs.push_back(obs());
    endtask

    task automatic test_reset();
        exp_t e, o;
        int idx = 0;
        rst_n = 1'b0;
        apply(idle(1'b1));
        repeat (2) @(posedge clk);
        #1;
        sb_exp.push_back(mk(1'b0, 16'h0100, 1'b0, 1'b0, 4'h0, 1'b0));
        sb_obs.push_back(obs());
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++)
            cyc(idle(1'b1), mk(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0, 4'h0, 1'b0));
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %s, expected %s", idx, fmt(o), fmt(e));
            end
            idx++;
        end
    endtask

    task automatic test_taken_jump();
        exp_t e, o;
        int idx = 0;
        cyc(st(1, 16'h0000, 0, 4'd0, 16'h0000, 1, 0, 4'b0100, 0, 1), mk(1, 16'h0104, 0, 0, 4'b0100, 0));
        cyc(st(1, 16'h0020, 1, 4'd1, 16'hFFF0, 0, 0, 4'b0000, 0, 1), mk(0, 16'h0010, 1, 1, 4'b0100, 0));
        cyc(idle(1'b1), mk(1, 16'h0010, 0, 1, 4'b0100, 0));
        cyc(idle(1'b1), mk(1, 16'h0011, 0, 1, 4'b0100, 0));
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL taken_jump[%0d]: got %s, expected %s", idx, fmt(o), fmt(e));
            end
            idx++;
        end
    endtask

    task automatic test_not_taken();
        exp_t e, o;
        int idx = 0;
        cyc(st(1, 16'h0020, 1, 4'd2, 16'hFFF0, 0, 0, 4'b0000, 0, 1), mk(1, 16'h0012, 0, 0, 4'b0100, 0));
        cyc(idle(1'b1), mk(1, 16'h0013, 0, 0, 4'b0100, 0));
        cyc(idle(1'b0), mk(1, 16'h0013, 0, 0, 4'b0100, 0));
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL not_taken[%0d]: got %s, expected %s", idx, fmt(o), fmt(e));
            end
            idx++;
        end
    endtask

    task automatic test_flag_and_jump();
        exp_t e, o;
        int idx = 0;
        cyc(st(1, 16'h0000, 0, 4'd0, 16'h0000, 1, 0, 4'b0000, 0, 1), mk(1, 16'h0014, 0, 0, 4'b0000, 0));
        cyc(st(1, 16'h0020, 1, 4'd1, 16'hFFF0, 1, 0, 4'b0100, 0, 1), mk(1, 16'h0015, 0, 0, 4'b0100, 0));
        cyc(st(1, 16'h0000, 0, 4'd0, 16'h0000, 0, 1, 4'b1011, 0, 1), mk(1, 16'h0016, 0, 0, 4'b0111, 0));
        cyc(st(1, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 4'b1111, 0, 0), mk(1, 16'h0016, 0, 0, 4'b0111, 0));
        cyc(st(0, 16'h0000, 0, 4'd0, 16'h0000, 1, 1, 4'b1000, 0, 1), mk(1, 16'h0017, 0, 0, 4'b0111, 0));
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL flag_and_jump[%0d]: got %s, expected %s", idx, fmt(o), fmt(e));
            end
            idx++;
        end
    endtask

    // Flags are N=0 Z=1 C=1 V=1 throughout.
    task automatic test_back_to_back();
        exp_t e, o;
        int idx = 0;
        logic [3:0]  nt_conds [8] = '{4'd15, 4'd9, 4'd11, 4'd4, 4'd8, 4'd2, 4'd5, 4'd13};
        logic [3:0]  tk_conds [8] = '{4'd14, 4'd1, 4'd3, 4'd7, 4'd10, 4'd12, 4'd6, 4'd0};
        logic [15:0] base, tgt;
        for (int i = 0; i < 8; i++)
            cyc(st(1, 16'h0040, 1, nt_conds[i], 16'h0008, 0, 0, 4'b0000, 0, 1),
                mk(1, 16'(16'h0018 + i), 0, 0, 4'b0111, 0));
        for (int k = 0; k < 8; k++) begin
            base = 16'(16'h0040 + 16 * k);
            tgt  = 16'(base + 16'h0008);
            cyc(st(1, base, 1, tk_conds[k], 16'h0008, 0, 0, 4'b0000, 0, 1), mk(0, tgt, 1, 1, 4'b0111, 0));
            cyc(st(1, 16'h0500, 1, 4'd0, 16'h0000, 1, 1, 4'b1000, 0, 1), mk(1, tgt, 0, 1, 4'b0111, 0));
        end
        cyc(idle(1'b1), mk(1, 16'h00B9, 0, 1, 4'b0111, 0));
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %s, expected %s", idx, fmt(o), fmt(e));
            end
            idx++;
        end
    endtask

    task automatic test_wrap_and_reset();
        exp_t e, o;
        int idx = 0;
        cyc(st(1, 16'hFFFF, 1, 4'd0, 16'h0002, 0, 0, 4'b0000, 0, 1), mk(0, 16'h0001, 1, 1, 4'b0111, 0));
        cyc(st(1, 16'h0500, 1, 4'd0, 16'h0000, 0, 0, 4'b0000, 0, 1), mk(1, 16'h0001, 0, 1, 4'b0111, 0));
        cyc(idle(1'b1), mk(1, 16'h0002, 0, 1, 4'b0111, 0));
        cyc(st(1, 16'hFFF0, 1, 4'd0, 16'h000F, 0, 0, 4'b0000, 0, 1), mk(0, 16'hFFFF, 1, 1, 4'b0111, 0));
        cyc(idle(1'b1), mk(1, 16'hFFFF, 0, 1, 4'b0111, 0));
        cyc(idle(1'b1), mk(1, 16'h0000, 0, 1, 4'b0111, 0));
        cyc(st(1, 16'h0200, 1, 4'd0, 16'h0010, 0, 0, 4'b0000, 0, 1), mk(0, 16'h0210, 1, 1, 4'b0111, 0));
        apply(idle(1'b1));
        rst_n = 1'b0;
        #1;
        sb_exp.push_back(mk(0, 16'h0100, 0, 0, 4'b0000, 0));
        sb_obs.push_back(obs());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(idle(1'b1), mk(1, 16'h0100, 0, 0, 4'b0000, 0));
        cyc(idle(1'b1), mk(1, 16'h0101, 0, 0, 4'b0000, 0));
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL wrap_and_reset[%0d]: got %s, expected %s", idx, fmt(o), fmt(e));
            end
            idx++;
        end
    endtask

    task automatic test_halt();
        exp_t e, o;
        int idx = 0;
        cyc(st(0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 4'b0000, 1, 1), mk(0, 16'h0102, 0, 0, 4'b0000, 1));
        cyc(st(1, 16'h0000, 0, 4'd0, 16'h0000, 0, 1, 4'b0011, 1, 1), mk(0, 16'h0102, 0, 0, 4'b0011, 1));
        cyc(st(0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 4'b0000, 1, 1), mk(0, 16'h0102, 0, 0, 4'b0011, 1));
        cyc(idle(1'b1), mk(1, 16'h0102, 0, 0, 4'b0011, 0));
        cyc(idle(1'b1), mk(1, 16'h0103, 0, 0, 4'b0011, 0));
        cyc(st(1, 16'h0300, 1, 4'd0, 16'h0005, 0, 0, 4'b0000, 1, 1), mk(0, 16'h0305, 1, 1, 4'b0011, 0));
        cyc(st(0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 4'b0000, 1, 1), mk(1, 16'h0305, 0, 1, 4'b0011, 0));
        cyc(st(0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 4'b0000, 1, 1), mk(0, 16'h0306, 0, 1, 4'b0011, 1));
        cyc(idle(1'b1), mk(1, 16'h0306, 0, 1, 4'b0011, 0));
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL halt[%0d]: got %s, expected %s", idx, fmt(o), fmt(e));
            end
            idx++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before the test sequence ended");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_taken_jump();
        test_not_taken();
        test_flag_and_jump();
        test_back_to_back();
        test_wrap_and_reset();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
